// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions.
// Holds the ImmSrc format encodings, common opcodes, and instruction field bit positions.
// The encoder, the immediate extractor and the decoder all take these values from here.
// Also holds a helper that checks whether an immediate fits a signed field.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_R = 2'b11
  } imm_src_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Field LSB positions within the 32-bit instruction word.
  localparam int unsigned OPCODE_LSB   = 0;
  localparam int unsigned RD_LSB       = 7;
  localparam int unsigned FUNCT3_LSB   = 12;
  localparam int unsigned RS1_LSB      = 15;
  localparam int unsigned RS2_LSB      = 20;
  localparam int unsigned FUNCT7_LSB   = 25;
  localparam int unsigned I_IMM_LSB    = 20;  // imm[11:0]
  localparam int unsigned S_IMM_LO_LSB = 7;   // imm[4:0]
  localparam int unsigned S_IMM_HI_LSB = 25;  // imm[11:5]
  localparam int unsigned B_IMM11_POS  = 7;   // imm[11]
  localparam int unsigned B_IMM_LO_LSB = 8;   // imm[4:1]
  localparam int unsigned B_IMM_HI_LSB = 25;  // imm[10:5]
  localparam int unsigned B_IMM12_POS  = 31;  // imm[12]

  // True when imm[31:top] are all equal, i.e. the value fits a signed field of width top+1.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned top);
    logic all_zero;
    logic all_one;
    all_zero = 1'b1;
    all_one  = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= top) begin
        all_zero = all_zero & ~imm[i];
        all_one  = all_one & imm[i];
      end
    end
    return all_zero | all_one;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational instruction-word packer.
// Selects the field layout for the I/S/B/R format chosen by i_ImmSrc.
// Places the immediate bits in their format-specific positions.
// Range-checks the immediate against the selected format.
// Ports:
//   i_ImmSrc                     format select (IMM_I/IMM_S/IMM_B/IMM_R)
//   i_Opcode, i_Rd, i_Rs1, i_Rs2,
//   i_Funct3, i_Funct7, i_Imm    decoded fields
//   o_Word                       encoded 32-bit instruction
//   o_Legal                      immediate fits the selected format
module imm_packer
  import riscv_pkg::*;
(
  input  logic [1:0]  i_ImmSrc,
  input  logic [6:0]  i_Opcode,
  input  logic [4:0]  i_Rd,
  input  logic [4:0]  i_Rs1,
  input  logic [4:0]  i_Rs2,
  input  logic [2:0]  i_Funct3,
  input  logic [6:0]  i_Funct7,
  input  logic [31:0] i_Imm,
  output logic [31:0] o_Word,
  output logic        o_Legal
);

  always_comb begin
    o_Word                     = '0;
    o_Legal                    = 1'b1;
    o_Word[OPCODE_LSB +: 7]    = i_Opcode;
    unique case (i_ImmSrc)
      IMM_I: begin
        o_Word[RD_LSB +: 5]     = i_Rd;
        o_Word[FUNCT3_LSB +: 3] = i_Funct3;
        o_Word[RS1_LSB +: 5]    = i_Rs1;
        o_Word[I_IMM_LSB +: 12] = i_Imm[11:0];
        o_Legal                 = imm_fits(i_Imm, 11);
      end
      IMM_S: begin
        o_Word[S_IMM_LO_LSB +: 5] = i_Imm[4:0];
        o_Word[FUNCT3_LSB +: 3]   = i_Funct3;
        o_Word[RS1_LSB +: 5]      = i_Rs1;
        o_Word[RS2_LSB +: 5]      = i_Rs2;
        o_Word[S_IMM_HI_LSB +: 7] = i_Imm[11:5];
        o_Legal                   = imm_fits(i_Imm, 11);
      end
      IMM_B: begin
        o_Word[B_IMM11_POS]       = i_Imm[11];
        o_Word[B_IMM_LO_LSB +: 4] = i_Imm[4:1];
        o_Word[FUNCT3_LSB +: 3]   = i_Funct3;
        o_Word[RS1_LSB +: 5]      = i_Rs1;
        o_Word[RS2_LSB +: 5]      = i_Rs2;
        o_Word[B_IMM_HI_LSB +: 6] = i_Imm[10:5];
        o_Word[B_IMM12_POS]       = i_Imm[12];
        // Branch offsets are halfword multiples; bit 0 has no encoding.
        o_Legal                   = imm_fits(i_Imm, 12) & ~i_Imm[0];
      end
      IMM_R: begin
        o_Word[RD_LSB +: 5]     = i_Rd;
        o_Word[FUNCT3_LSB +: 3] = i_Funct3;
        o_Word[RS1_LSB +: 5]    = i_Rs1;
        o_Word[RS2_LSB +: 5]    = i_Rs2;
        o_Word[FUNCT7_LSB +: 7] = i_Funct7;
      end
      default: begin
        o_Word  = '0;
        o_Legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a streaming memory-write output.
// Packs decoded fields into 32-bit words and presents them on a single registered output stage.
// Each word goes out with a sequential, word-aligned write address.
// Fields whose immediate is out of range are consumed and dropped, and a sticky error is raised.
// Ports:
//   i_Clk, i_Reset                 clock, synchronous active-high reset
//   i_Restart                      flush output stage, reload address, clear count
//   i_InValid / o_InReady          field-side handshake
//   i_ImmSrc .. i_Imm              decoded fields
//   o_OutValid / i_OutReady        memory-side handshake
//   o_Instruction, o_Addr          presented word and its write address
//   o_Count                        words delivered, saturating
//   o_Err / i_ErrClr               sticky range error and its clear
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Restart,
  input  logic                  i_InValid,
  output logic                  o_InReady,
  input  logic [1:0]            i_ImmSrc,
  input  logic [6:0]            i_Opcode,
  input  logic [4:0]            i_Rd,
  input  logic [4:0]            i_Rs1,
  input  logic [4:0]            i_Rs2,
  input  logic [2:0]            i_Funct3,
  input  logic [6:0]            i_Funct7,
  input  logic [31:0]           i_Imm,
  output logic                  o_OutValid,
  input  logic                  i_OutReady,
  output logic [31:0]           o_Instruction,
  output logic [ADDR_WIDTH-1:0] o_Addr,
  output logic [15:0]           o_Count,
  output logic                  o_Err,
  input  logic                  i_ErrClr
);

  out_state_e            state_q;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           count_q;
  logic                  err_q;

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        accept;
  logic        deliver;

  imm_packer u_imm_packer (
    .i_ImmSrc (i_ImmSrc),
    .i_Opcode (i_Opcode),
    .i_Rd     (i_Rd),
    .i_Rs1    (i_Rs1),
    .i_Rs2    (i_Rs2),
    .i_Funct3 (i_Funct3),
    .i_Funct7 (i_Funct7),
    .i_Imm    (i_Imm),
    .o_Word   (packed_word),
    .o_Legal  (packed_legal)
  );

  // Ready passes straight through from the sink so a full stage can refill on delivery.
  assign o_InReady = ~(i_Reset | i_Restart) & ((state_q == StEmpty) | i_OutReady);
  assign accept    = i_InValid & o_InReady;
  assign deliver   = (state_q == StFull) & i_OutReady;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= StEmpty;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // A dropped word in the same cycle as a clear must still be reported.
      if (accept && !packed_legal) begin
        err_q <= 1'b1;
      end else if (i_ErrClr) begin
        err_q <= 1'b0;
      end

      if (i_Restart) begin
        state_q <= StEmpty;
        addr_q  <= BASE_ADDR;
        count_q <= '0;
      end else begin
        if (deliver) begin
          addr_q <= addr_q + ADDR_WIDTH'(4);
          if (count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
          end
        end
        if (accept && packed_legal) begin
          instr_q <= packed_word;
          state_q <= StFull;
        end else if (deliver) begin
          state_q <= StEmpty;
        end
      end
    end
  end

  assign o_OutValid    = (state_q == StFull);
  assign o_Instruction = instr_q;
  assign o_Addr        = addr_q;
  assign o_Count       = count_q;
  assign o_Err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  src;
    logic [31:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready, err_clr;
  logic        in_ready, out_valid, err;
  logic [1:0]  imm_src;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, instr, addr;
  logic [15:0] count;

  logic        w_in_valid, w_out_ready, w_in_ready, w_valid, w_err;
  logic [31:0] w_instr;
  logic [3:0]  w_addr;
  logic [15:0] w_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .i_Clk(clk), .i_Reset(reset), .i_Restart(restart), .i_InValid(in_valid),
    .o_InReady(in_ready), .i_ImmSrc(imm_src), .i_Opcode(opcode), .i_Rd(rd), .i_Rs1(rs1),
    .i_Rs2(rs2), .i_Funct3(funct3), .i_Funct7(funct7), .i_Imm(imm), .o_OutValid(out_valid),
    .i_OutReady(out_ready), .o_Instruction(instr), .o_Addr(addr), .o_Count(count),
    .o_Err(err), .i_ErrClr(err_clr)
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'h0)) dut_w (
    .i_Clk(clk), .i_Reset(reset), .i_Restart(1'b0), .i_InValid(w_in_valid),
    .o_InReady(w_in_ready), .i_ImmSrc(imm_src), .i_Opcode(opcode), .i_Rd(rd), .i_Rs1(rs1),
    .i_Rs2(rs2), .i_Funct3(funct3), .i_Funct7(funct7), .i_Imm(imm), .o_OutValid(w_valid),
    .i_OutReady(w_out_ready), .o_Instruction(w_instr), .o_Addr(w_addr), .o_Count(w_count),
    .o_Err(w_err), .i_ErrClr(1'b0)
  );

  int n_chk = 0;
  int n_fail = 0;

  vec_t        vecs[12];
  exp_t        sb[$];
  logic [31:0] exp_addr;
  logic [15:0] exp_count;
  logic        exp_err;
  logic        cur_legal;
  logic [31:0] cur_word;
  logic        last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract_imm(input logic [1:0] src, input logic [31:0] w);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Compare current outputs against the scoreboard, then advance the model by one edge.
  task automatic mon();
    logic exp_rdy, acc;
    exp_t e;
    exp_rdy = !restart && (sb.size() == 0 || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    chk("count", {16'b0, count}, {16'b0, exp_count});
    chk("err", {31'b0, err}, {31'b0, exp_err});
    if (sb.size() != 0) begin
      chk("instr", instr, sb[0].word);
      chk("addr", addr, exp_addr);
    end
    acc = in_valid && exp_rdy;
    last_acc = acc;
    if (restart) begin
      sb.delete();
      exp_addr  = 32'h0;
      exp_count = 16'h0;
    end else begin
      if (sb.size() != 0 && out_ready) begin
        e = sb.pop_front();
        if (e.src != 2'b11) chk("roundtrip_imm", extract_imm(e.src, instr), e.imm);
        exp_addr = exp_addr + 32'd4;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      end
      if (acc && cur_legal) begin
        e.word = cur_word;
        e.src  = imm_src;
        e.imm  = imm;
        sb.push_back(e);
      end
    end
    if (acc && !cur_legal) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i);
    imm_src   = vecs[i].src;
    opcode    = vecs[i].op;
    rd        = vecs[i].rd;
    rs1       = vecs[i].rs1;
    rs2       = vecs[i].rs2;
    funct3    = vecs[i].f3;
    funct7    = vecs[i].f7;
    imm       = vecs[i].imm;
    cur_legal = vecs[i].legal;
    cur_word  = vecs[i].word;
  endtask

  task automatic send(input int i);
    bit done;
    done = 0;
    set_fields(i);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (last_acc) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    chk("drain_empty", sb.size(), 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  wa[5];
    logic [15:0] wc[5];
    //           src    op          rd     rs1    rs2    f3      f7          imm  legal word
    vecs[0]  = '{2'b00, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF3_0293};
    vecs[1]  = '{2'b01, 7'b0100011, 5'd0, 5'd2, 5'd7, 3'b010, 7'd0, 32'h0000_0008, 1, 32'h0071_2423};
    vecs[2]  = '{2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 1, 32'hFE20_8EE3};
    vecs[3]  = '{2'b11, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h1234_5678, 1, 32'h0020_81B3};
    vecs[4]  = '{2'b11, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'hFFFF_0000, 1, 32'h4020_81B3};
    vecs[5]  = '{2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800, 1, 32'h8000_0093};
    vecs[6]  = '{2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_07FF, 1, 32'h7FF0_0093};
    vecs[7]  = '{2'b10, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b001, 7'd0, 32'h0000_0FFE, 1, 32'h7E00_1FE3};
    vecs[8]  = '{2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800, 0, 32'h0};
    vecs[9]  = '{2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'h0000_0003, 0, 32'h0};
    vecs[10] = '{2'b01, 7'b0100011, 5'd0, 5'd2, 5'd7, 3'b010, 7'd0, 32'hFFFF_F7FF, 0, 32'h0};
    vecs[11] = '{2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'h0000_1000, 0, 32'h0};

    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0;
    set_fields(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_w_addr", {28'b0, w_addr}, 32'd0);
    exp_addr = 32'h0; exp_count = 16'h0; exp_err = 1'b0;

    // ADDI x5,x6,-1 with the sink ready.
    out_ready = 1'b1;
    send(0);
    chk("addi_word", instr, 32'hFFF3_0293);
    chk("addi_addr", addr, 32'd0);
    drain();
    chk("addi_addr_after", addr, 32'd4);
    chk("addi_count_after", {16'b0, count}, 32'd1);
    send(1);
    send(2);
    drain();

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart1_addr", addr, 32'd0);
    chk("restart1_count", {16'b0, count}, 32'd0);

    // Three back-to-back words against a stalled sink.
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(3);
    send(4);
    send(5);
    drain();
    chk("bp_addr", addr, 32'd12);
    chk("bp_count", {16'b0, count}, 32'd3);

    // Full vector table, legal and illegal, sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(i);
      if (!vecs[i].legal) chk("illegal_sets_err", {31'b0, err}, 32'd1);
    end
    drain();

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr", {31'b0, err}, 32'd0);
    err_clr = 1'b1;
    send(8);
    err_clr = 1'b0;
    chk("errclr_vs_set", {31'b0, err}, 32'd1);

    // Restart while full, with a same-cycle delivery and accept both offered.
    out_ready = 1'b0;
    send(6);
    set_fields(7);
    restart = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    restart = 1'b0; in_valid = 1'b0;
    chk("restart_valid", {31'b0, out_valid}, 32'd0);
    chk("restart_addr", addr, 32'd0);
    chk("restart_count", {16'b0, count}, 32'd0);
    chk("restart_err", {31'b0, err}, 32'd1);
    tick();

    // Narrow-address instance: wrap and saturation.
    set_fields(0);
    wa[0] = 4'd0; wa[1] = 4'd4; wa[2] = 4'd8; wa[3] = 4'd12; wa[4] = 4'd0;
    wc[0] = 16'd0; wc[1] = 16'd1; wc[2] = 16'd2; wc[3] = 16'd3; wc[4] = 16'd4;
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wrap_addr", {28'b0, w_addr}, {28'b0, wa[k]});
      chk("wrap_count", {16'b0, w_count}, {16'b0, wc[k]});
    end
    w_in_valid = 1'b0;
    tick();
    chk("wrap_drain_addr", {28'b0, w_addr}, 32'd4);
    chk("wrap_drain_valid", {31'b0, w_valid}, 32'd0);
    force dut_w.count_q = 16'hFFFF;
    w_in_valid = 1'b1;
    tick();
    release dut_w.count_q;
    w_in_valid = 1'b0;
    chk("sat_preload", {16'b0, w_count}, 32'h0000_FFFF);
    tick();
    chk("sat_count", {16'b0, w_count}, 32'h0000_FFFF);
    chk("sat_valid", {31'b0, w_valid}, 32'd0);
    chk("sat_addr", {28'b0, w_addr}, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes decoded RISC-V fields (opcode, registers, funct fields, 32-bit immediate) into 32-bit instruction words. This is the inverse of the core's immediate extraction.
- Streams the encoded words, with sequential word addresses, to the instruction-memory write port.
- Used by the boot/program loader and by self-checking benches for encode->decode round-trips.
- Range-checks immediates; valid/ready handshake on both sides with a single registered output stage.

Parameters:
- ADDR_WIDTH, 32, width of o_Addr.
- BASE_ADDR, 32'h0000_0000, first write address after reset or restart; must be 4-byte aligned.

Ports:
- i_Clk  in  1  clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Restart  in  1  sync pulse: flush output stage, reload address, clear count.
- i_InValid  in  1  input fields valid.
- o_InReady  out  1  encoder can accept fields this cycle.
- i_ImmSrc  in  2  format select: 00 I, 01 S, 10 B, 11 R.
- i_Opcode  in  7  opcode field.
- i_Rd  in  5  destination register.
- i_Rs1  in  5  source register 1.
- i_Rs2  in  5  source register 2.
- i_Funct3  in  3  funct3 field.
- i_Funct7  in  7  funct7 field; R only.
- i_Imm  in  32  signed immediate, byte offset for B.
- o_OutValid  out  1  o_Instruction/o_Addr valid.
- i_OutReady  in  1  memory accepts word.
- o_Instruction  out  32  encoded word.
- o_Addr  out  ADDR_WIDTH  write address of o_Instruction.
- o_Count  out  16  words delivered since reset/restart; saturates at 16'hFFFF.
- o_Err  out  1  sticky: an out-of-range immediate was dropped.
- i_ErrClr  in  1  clears o_Err.

Behaviour:
- Reset, sync: o_OutValid=0, o_Instruction=0, o_Addr=BASE_ADDR, o_Count=0, o_Err=0.
- Output stage has two states, EMPTY (o_OutValid=0) and FULL (o_OutValid=1).
- o_InReady = !o_OutValid || i_OutReady, combinational. It is forced to 0 while i_Reset or i_Restart is high.
- Accept happens when i_InValid && o_InReady. A legal accept loads o_Instruction next edge and the state goes FULL. Latency is 1 cycle.
- Delivery happens when o_OutValid && i_OutReady. Then:
  - o_Addr += 4, wrapping modulo 2^ADDR_WIDTH.
  - o_Count += 1, saturating.
  - State goes EMPTY unless a simultaneous legal accept refills it. Back-to-back throughput is 1 word/cycle.
- While FULL and !i_OutReady, o_Instruction and o_Addr hold stable. o_Addr is the address of the word currently presented.
- Encoding by i_ImmSrc:
  - I: {Imm[11:0], Rs1, Funct3, Rd, Opcode}.
  - S: {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}.
  - B: {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}.
  - R: {Funct7, Rs2, Rs1, Funct3, Rd, Opcode}; i_Imm ignored.
- Range check:
  - I/S legal iff Imm[31:11] is all 0 or all 1.
  - B legal iff Imm[31:12] is all 0 or all 1 and Imm[0]=0.
  - R is always legal.
- Illegal accept: the fields are consumed (handshake completes) but dropped. Output state, o_Addr and o_Count are unchanged; o_Err <= 1.
- o_Err is cleared by i_ErrClr. If an illegal accept and i_ErrClr occur in the same cycle, the set wins.
- i_Restart: next edge sets o_OutValid=0, o_Addr=BASE_ADDR, o_Count=0. o_Err is retained. Restart overrides any same-cycle accept or delivery; an in-flight word is discarded.
- i_Reset overrides everything, including i_Restart.
- Invariant: decoding o_Instruction with the core's immediate extractor reproduces i_Imm for every legal I/S/B input (B with bit 0 = 0).

Decomposition:
- Shared package riscv_pkg:
  - ImmSrc encodings IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_R=2'b11.
  - Opcode constants.
  - Field bit-position constants, shared with the immediate extractor and the decoder.
- One combinational sub-module imm_packer holds the format mux and range check. Ports: i_ImmSrc, fields in; o_Word, o_Legal out.
- instr_encoder holds the handshake, output register, address/count and error logic.

Test Plan:
- I-type: ADDI x5,x6,-1 (Opcode 0010011, Funct3 000, Imm 32'hFFFF_FFFF), i_OutReady=1 -> next cycle o_Instruction=32'hFFF3_0293, o_Addr=0; after delivery o_Addr=4, o_Count=1.
- S and B: SW x7,8(x2) -> 32'h0071_2423. BEQ x1,x2,-4 (Imm 32'hFFFF_FFFC) -> 32'hFE20_8EE3. Each word passes the immediate-extractor round-trip.
- Backpressure: 3 back-to-back words with i_OutReady=0 for 3 cycles -> o_InReady=0 while FULL, first word held stable; after release the words are delivered at addresses 0,4,8 one per cycle, with no loss or duplication.
- Range errors:
  - I Imm=2048 -> dropped, o_Err=1, o_Count unchanged.
  - B Imm=3 (odd) -> dropped, o_Err stays 1.
  - I Imm=-2048 -> legal.
  - i_ErrClr -> o_Err=0; i_ErrClr together with an illegal accept -> o_Err=1.
- Restart: i_Restart while FULL with i_OutReady=1 and i_InValid=1 -> no delivery, no accept; next cycle o_OutValid=0, o_Addr=BASE_ADDR, o_Count=0, o_Err retained.
- Wrap/saturation, with ADDR_WIDTH=4 and the counter preloaded via force:
  - delivery at o_Addr=12 -> o_Addr=0;
  - o_Count=16'hFFFF plus delivery -> stays 16'hFFFF.
